// File: rtl/serial_magnitude_comparator_if.sv
// serial_magnitude_comparator_if: operand, cascade and handshake bundle for the serial comparator
interface serial_magnitude_comparator_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic signed_cmp;
  logic l;
  logic g;
  logic e;
  logic busy;
  logic done;
  logic LT;
  logic GT;
  logic EQ;
  modport master(output start, a, b, signed_cmp, l, g, e, input busy, done, LT, GT, EQ);
  modport slave(input start, a, b, signed_cmp, l, g, e, output busy, done, LT, GT, EQ);
endinterface

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: MSB-first digit-serial cascadable magnitude compare with early exit
module serial_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic clk,
  input logic rst,
  serial_magnitude_comparator_if.slave bus
);
  localparam int N = WIDTH / DIGIT;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  typedef enum logic {IDLE, COMPARE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] ra, rb, ra_n, rb_n;
  logic [IW-1:0] idx, idx_n;
  logic [2:0] cas, cas_n;
  logic [2:0] res, res_n;
  logic done_r, done_n;
  logic [DIGIT-1:0] da, db;
  // Operands are shifted left each step so the digit under test is always the top DIGIT bits
  assign da = ra[WIDTH-1 -: DIGIT];
  assign db = rb[WIDTH-1 -: DIGIT];
  assign bus.busy = state == COMPARE;
  assign bus.done = done_r;
  assign {bus.LT, bus.GT, bus.EQ} = res;
  // State, captured operands, cascade bits and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      idx <= '0;
      cas <= '0;
      res <= '0;
      done_r <= 1'b0;
    end else begin
      state <= state_n;
      ra <= ra_n;
      rb <= rb_n;
      idx <= idx_n;
      cas <= cas_n;
      res <= res_n;
      done_r <= done_n;
    end
  end
  // Capture on start; resolve on first differing digit or fall back to cascade bits on the last one
  always_comb begin
    state_n = state;
    ra_n = ra;
    rb_n = rb;
    idx_n = idx;
    cas_n = cas;
    res_n = res;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (bus.start) begin
        state_n = COMPARE;
        ra_n = bus.a ^ {bus.signed_cmp, {(WIDTH-1){1'b0}}};
        rb_n = bus.b ^ {bus.signed_cmp, {(WIDTH-1){1'b0}}};
        idx_n = '0;
        cas_n = {bus.l, bus.g, bus.e};
      end
    end else if (da != db || idx == LAST) begin
      state_n = IDLE;
      done_n = 1'b1;
      res_n = da > db ? 3'b010 : da < db ? 3'b100 : cas;
    end else begin
      ra_n = ra << DIGIT;
      rb_n = rb << DIGIT;
      idx_n = idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator: directed vectors across DIGIT=1/2/4 plus handshake and reset sequences
module tb_serial_magnitude_comparator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_magnitude_comparator_if #(.WIDTH(8)) if1();
  serial_magnitude_comparator_if #(.WIDTH(8)) if2();
  serial_magnitude_comparator_if #(.WIDTH(8)) if4();
  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1)) d1(.clk(clk), .rst(rst), .bus(if1.slave));
  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) d2(.clk(clk), .rst(rst), .bus(if2.slave));
  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(4)) d4(.clk(clk), .rst(rst), .bus(if4.slave));
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic s;
    logic l;
    logic g;
    logic e;
    logic [2:0] res;
    int lat1;
    int lat2;
    int lat4;
  } vec_t;
  vec_t vecs[12];
  int checks = 0;
  int errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic drive_all(input logic [7:0] a, input logic [7:0] b, input logic s, input logic l,
                           input logic g, input logic e, input logic st);
    if1.a = a; if1.b = b; if1.signed_cmp = s; if1.l = l; if1.g = g; if1.e = e; if1.start = st;
    if2.a = a; if2.b = b; if2.signed_cmp = s; if2.l = l; if2.g = g; if2.e = e; if2.start = st;
    if4.a = a; if4.b = b; if4.signed_cmp = s; if4.l = l; if4.g = g; if4.e = e; if4.start = st;
  endtask
  task automatic run_vec(input vec_t v, input int n);
    int l1, l2, l4;
    @(negedge clk);
    drive_all(v.a, v.b, v.s, v.l, v.g, v.e, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive_all(~v.a, ~v.b, ~v.s, ~v.l, ~v.g, ~v.e, 1'b0);
    check($sformatf("v%0d busy", n), {29'd0, if1.busy, if2.busy, if4.busy}, 32'd7);
    l1 = 0; l2 = 0; l4 = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (if1.done && l1 == 0) l1 = c;
      if (if2.done && l2 == 0) l2 = c;
      if (if4.done && l4 == 0) l4 = c;
    end
    check($sformatf("v%0d lat d1", n), l1, v.lat1);
    check($sformatf("v%0d lat d2", n), l2, v.lat2);
    check($sformatf("v%0d lat d4", n), l4, v.lat4);
    check($sformatf("v%0d res d1", n), {if1.LT, if1.GT, if1.EQ}, v.res);
    check($sformatf("v%0d res d2", n), {if2.LT, if2.GT, if2.EQ}, v.res);
    check($sformatf("v%0d res d4", n), {if4.LT, if4.GT, if4.EQ}, v.res);
  endtask
  task automatic wait_done1(output int lat, input int pulse_at, input logic [7:0] pulse_a);
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == pulse_at) begin
        if1.start = 1'b1;
        if1.a = pulse_a;
      end else begin
        if1.start = 1'b0;
      end
      if (if1.done) begin
        lat = c;
        break;
      end
    end
  endtask
  initial begin
    int lat;
    int seen;
    vecs[0]  = '{8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 8, 4, 2};
    vecs[1]  = '{8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1, 1, 1};
    vecs[2]  = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 1, 1, 1};
    vecs[3]  = '{8'h3C, 8'h3D, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 8, 4, 2};
    vecs[4]  = '{8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 8, 4, 2};
    vecs[5]  = '{8'hF0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 1, 1, 1};
    vecs[6]  = '{8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 8, 4, 2};
    vecs[7]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 3'b111, 8, 4, 2};
    vecs[8]  = '{8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 8, 4, 2};
    vecs[9]  = '{8'h02, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 7, 4, 2};
    vecs[10] = '{8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 3, 2, 1};
    vecs[11] = '{8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 1, 1, 1};
    drive_all(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset d1", {27'd0, if1.busy, if1.done, if1.LT, if1.GT, if1.EQ}, 32'd0);
    check("reset d2", {27'd0, if2.busy, if2.done, if2.LT, if2.GT, if2.EQ}, 32'd0);
    check("reset d4", {27'd0, if4.busy, if4.done, if4.LT, if4.GT, if4.EQ}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);
    @(negedge clk);
    if1.a = 8'h00; if1.b = 8'h01; if1.signed_cmp = 1'b0; if1.l = 1'b0; if1.g = 1'b0; if1.e = 1'b1;
    if1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if1.start = 1'b0;
    wait_done1(lat, 2, 8'hFF);
    check("ignored start lat", lat, 8);
    check("ignored start res", {if1.LT, if1.GT, if1.EQ}, 3'b100);
    check("busy low at done", {31'd0, if1.busy}, 32'd0);
    if1.a = 8'h02; if1.b = 8'h01; if1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if1.start = 1'b0;
    wait_done1(lat, 0, 8'h02);
    check("back-to-back lat", lat, 7);
    check("back-to-back res", {if1.LT, if1.GT, if1.EQ}, 3'b010);
    @(negedge clk);
    if1.a = 8'hAA; if1.b = 8'hAA; if1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if1.start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("mid reset outs", {27'd0, if1.busy, if1.done, if1.LT, if1.GT, if1.EQ}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (if1.done || if1.busy) seen = 1;
    end
    check("no done after reset", seen, 0);
    if1.a = 8'h01; if1.b = 8'h00; if1.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if1.start = 1'b0;
    wait_done1(lat, 0, 8'h01);
    check("post reset lat", lat, 8);
    check("post reset res", {if1.LT, if1.GT, if1.EQ}, 3'b010);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
